// File: rtl/mem_loader.sv
// Stream-to-memory loader: copies `length` words from a read-strobed source into memory at base_addr.
// Optional readback verification of the written block is enabled by defining LOADER_VERIFY_EN.
module mem_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  src_read,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] checksum,
    output logic                  verify_ok,
    output logic                  verify_fail
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WRITE,
        VADDR,
        VCHK,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH:0]   idx_q, idx_d;
    logic [DATA_WIDTH-1:0] checksum_q, checksum_d;

    logic [ADDR_WIDTH:0]   idx_next;
    logic                  last_word;
    logic [ADDR_WIDTH-1:0] addr_cur;

`ifdef LOADER_VERIFY_EN
    logic [DATA_WIDTH-1:0] rsum_q, rsum_d;
    logic                  verify_ok_q, verify_ok_d;
    logic                  verify_fail_q, verify_fail_d;
`else
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;
`endif

    // idx is one bit wider than an address so a full 2^ADDR_WIDTH block can be counted.
    assign idx_next  = idx_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
    assign last_word = (idx_next == len_q);
    assign addr_cur  = base_q + idx_q[ADDR_WIDTH-1:0];

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        idx_d      = idx_q;
        checksum_d = checksum_q;
`ifdef LOADER_VERIFY_EN
        rsum_d        = rsum_q;
        verify_ok_d   = verify_ok_q;
        verify_fail_d = verify_fail_q;
`endif
        src_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = (state_q != IDLE);
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d     = base_addr;
                    len_d      = length;
                    idx_d      = '0;
                    checksum_d = '0;
`ifdef LOADER_VERIFY_EN
                    rsum_d        = '0;
                    verify_ok_d   = 1'b0;
                    verify_fail_d = 1'b0;
`endif
                    state_d    = (length == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                src_read = 1'b1;
                state_d  = WRITE;
            end
            WRITE: begin
                mem_addr   = addr_cur;
                mem_wdata  = src_data;
                mem_write  = 1'b1;
                checksum_d = checksum_q + src_data;
                if (last_word) begin
`ifdef LOADER_VERIFY_EN
                    idx_d   = '0;
                    state_d = VADDR;
`else
                    state_d = DONE;
`endif
                end else begin
                    idx_d   = idx_next;
                    state_d = FETCH;
                end
            end
`ifdef LOADER_VERIFY_EN
            VADDR: begin
                mem_addr = addr_cur;
                state_d  = VCHK;
            end
            VCHK: begin
                rsum_d = rsum_q + mem_rdata;
                if (last_word) begin
                    verify_ok_d   = (rsum_d == checksum_q);
                    verify_fail_d = (rsum_d != checksum_q);
                    state_d       = DONE;
                end else begin
                    idx_d   = idx_next;
                    state_d = VADDR;
                end
            end
`endif
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort outranks every transition; the partial checksum is kept for inspection.
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
`ifdef LOADER_VERIFY_EN
            verify_ok_d   = verify_ok_q;
            verify_fail_d = verify_fail_q;
`endif
        end
    end

    // NOTE: the asynchronous reset reaches the state register, so every strobe decoded from it drops at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            checksum_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep all flops updating from the same pre-edge values.
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            checksum_q <= checksum_d;
        end
    end

`ifdef LOADER_VERIFY_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rsum_q        <= '0;
            verify_ok_q   <= 1'b0;
            verify_fail_q <= 1'b0;
        end else begin
            rsum_q        <= rsum_d;
            verify_ok_q   <= verify_ok_d;
            verify_fail_q <= verify_fail_d;
        end
    end

    assign verify_ok   = verify_ok_q;
    assign verify_fail = verify_fail_q;
`else
    assign verify_ok   = 1'b0;
    assign verify_fail = 1'b0;
`endif

    assign checksum = checksum_q;

endmodule

// File: tb/tb_mem_loader.sv
// Bench for mem_loader: source stream and RAM models, write scoreboard, vector table plus abort/reset/busy-start sequences.
// Expected verify flags and latencies follow LOADER_VERIFY_EN when it is defined.
module tb_mem_loader;

    localparam int DW = 8;
    localparam int AW = 8;
`ifdef LOADER_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          src_read;
    logic [DW-1:0] src_data = '0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_write;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;
    logic          done;
    logic [DW-1:0] checksum;
    logic          verify_ok;
    logic          verify_fail;

    mem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .base_addr  (base_addr),
        .length     (length),
        .src_read   (src_read),
        .src_data   (src_data),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_write  (mem_write),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum),
        .verify_ok  (verify_ok),
        .verify_fail(verify_fail)
    );

    always #5 clock = ~clock;

    logic [DW-1:0]    ram [0:(1<<AW)-1];
    logic             corrupt_en = 1'b0;
    logic [AW-1:0]    corrupt_addr = '0;
    logic [DW-1:0]    src_q[$];
    logic [AW+DW-1:0] sb_q[$];
    int n_checks = 0;
    int n_pass = 0;
    int n_src_reads = 0;
    int n_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Source stream and RAM responders.
    always @(posedge clock) begin
        if (src_read) begin
            if (src_q.size() > 0) src_data <= src_q.pop_front();
            else src_data <= '0;
        end
        if (mem_write) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr] + ((corrupt_en && mem_addr == corrupt_addr) ? 8'd1 : 8'd0);
    end

    // Monitor: scoreboard for writes plus event counters.
    always @(negedge clock) begin
        logic [AW+DW-1:0] exp_wr;
        if (src_read) n_src_reads++;
        if (done) n_done++;
        if (src_read && mem_write) check("rd_wr_overlap", 1, 0);
        if (mem_write) begin
            if (sb_q.size() == 0) check("unexpected_write", 1, 0);
            else begin
                exp_wr = sb_q.pop_front();
                check("write_addr_data", {16'd0, mem_addr, mem_wdata}, {16'd0, exp_wr});
            end
        end
    end

    typedef struct {
        logic [AW-1:0] base;
        logic [AW:0]   len;
        logic [DW-1:0] first;
        logic [DW-1:0] step;
        logic [DW-1:0] exp_sum;
        bit            corrupt;
        int            glitch;   // cycle at which a stray start is pulsed while busy; 0 = none
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input vec_t v, input string tag);
        logic [DW-1:0] d;
        int cyc;
        int exp_lat;
        bit exp_ok;
        bit exp_fail;
        src_q.delete();
        sb_q.delete();
        n_src_reads = 0;
        n_done = 0;
        corrupt_en = v.corrupt;
        corrupt_addr = v.base + 8'd3;
        d = v.first;
        for (int i = 0; i < int'(v.len); i++) begin
            src_q.push_back(d);
            sb_q.push_back({v.base + AW'(i), d});
            d = d + v.step;
        end
        exp_lat  = 2 * int'(v.len) + 1 + ((VERIFY && v.len != 0) ? 2 * int'(v.len) : 0);
        exp_ok   = VERIFY && (v.len != 0) && !v.corrupt;
        exp_fail = VERIFY && (v.len != 0) && v.corrupt;

        base_addr = v.base;
        length = v.len;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < exp_lat + 20) begin
            @(posedge clock); #1;
            cyc++;
            if (cyc == v.glitch) begin
                start = 1'b1;
                base_addr = 8'h90;
                length = 9'd2;
            end else start = 1'b0;
        end
        start = 1'b0;
        check({tag, "_done_latency"}, cyc, exp_lat);
        check({tag, "_busy_in_done"}, {31'd0, busy}, 1);
        check({tag, "_checksum"}, {24'd0, checksum}, {24'd0, v.exp_sum});
        @(posedge clock); #1;
        check({tag, "_busy_after"}, {31'd0, busy}, 0);
        check({tag, "_verify_ok"}, {31'd0, verify_ok}, {31'd0, exp_ok});
        check({tag, "_verify_fail"}, {31'd0, verify_fail}, {31'd0, exp_fail});
        check({tag, "_pending_writes"}, sb_q.size(), 0);
        check({tag, "_src_reads"}, n_src_reads, int'(v.len));
        check({tag, "_done_pulses"}, n_done, 1);
        if (v.glitch != 0) begin
            repeat (5) @(posedge clock);
            #1;
            check({tag, "_no_restart_busy"}, {31'd0, busy}, 0);
            check({tag, "_no_restart_reads"}, n_src_reads, int'(v.len));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_src_read"}, {31'd0, src_read}, 0);
        check({tag, "_mem_write"}, {31'd0, mem_write}, 0);
        check({tag, "_busy"}, {31'd0, busy}, 0);
        check({tag, "_done"}, {31'd0, done}, 0);
        check({tag, "_verify"}, {30'd0, verify_ok, verify_fail}, 0);
        check({tag, "_checksum"}, {24'd0, checksum}, 0);
        check({tag, "_mem_addr_wdata"}, {16'd0, mem_addr, mem_wdata}, 0);
    endtask

    initial begin
        int cyc;
        int wr;
        for (int i = 0; i < (1 << AW); i++) ram[i] = '0;

        //            base    len      first  step  sum    corrupt glitch
        vecs[0] = '{8'h00, 9'd128, 8'h00, 8'd1, 8'hC0, 1'b0, 0};
        vecs[1] = '{8'hFE, 9'd4,   8'h01, 8'd1, 8'h0A, 1'b0, 0};
        vecs[2] = '{8'h33, 9'd0,   8'h00, 8'd0, 8'h00, 1'b0, 0};
        vecs[3] = '{8'h10, 9'd8,   8'hF0, 8'd3, 8'hD4, 1'b0, 0};
        vecs[4] = '{8'h10, 9'd8,   8'hF0, 8'd3, 8'hD4, 1'b1, 0};
        vecs[5] = '{8'h80, 9'd256, 8'h00, 8'd1, 8'h80, 1'b0, 0};
        vecs[6] = '{8'h40, 9'd8,   8'h01, 8'd1, 8'h24, 1'b0, 5};

        #1 reset = 1'b0;
        #2;
        check_all_zero("reset");
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Abort during the third WRITE of a 16-word load.
        src_q.delete();
        sb_q.delete();
        n_done = 0;
        corrupt_en = 1'b0;
        for (int i = 0; i < 16; i++) src_q.push_back(8'h21 + 8'(i));
        for (int i = 0; i < 3; i++) sb_q.push_back({8'h50 + 8'(i), 8'h21 + 8'(i)});
        base_addr = 8'h50;
        length = 9'd16;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        wr = 0;
        cyc = 0;
        while (cyc < 40) begin
            if (mem_write) wr++;
            if (wr == 3) break;
            @(posedge clock); #1;
            cyc++;
        end
        check("abort_reached_third_write", wr, 3);
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        check("abort_busy_next", {31'd0, busy}, 0);
        check("abort_no_src_read", {31'd0, src_read}, 0);
        repeat (4) @(posedge clock);
        #1;
        check("abort_no_done", n_done, 0);
        check("abort_write_count", sb_q.size(), 0);
        check("abort_partial_checksum", {24'd0, checksum}, 32'h66);
        run_vec(vecs[1], "after_abort");

        // Reset pulsed in the middle of a load.
        src_q.delete();
        sb_q.delete();
        for (int i = 0; i < 16; i++) begin
            src_q.push_back(8'h80 + 8'(i));
            sb_q.push_back({8'(i), 8'h80 + 8'(i)});
        end
        base_addr = 8'h00;
        length = 9'd16;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        cyc = 0;
        while (!mem_write && cyc < 10) begin
            @(posedge clock); #1;
            cyc++;
        end
        check("midreset_write_seen", {31'd0, mem_write}, 1);
        reset = 1'b0;
        #1;
        check_all_zero("midreset");
        sb_q.delete();
        src_q.delete();
        n_done = 0;
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        check("midreset_idle_after", {31'd0, busy}, 0);
        check("midreset_no_done", n_done, 0);
        run_vec(vecs[1], "after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
